// File: rtl/stump_sequencer_pkg.sv
// Shared Stump sequencer definitions: state encodings, LDST opcode, flag payload.
package stump_sequencer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10
    } state_e;

    localparam logic [OP_W-1:0] LDST = 3'b111;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    function automatic logic is_ldst(input logic [DATA_W-1:0] instr);
        return instr[DATA_W-1 -: OP_W] == LDST;
    endfunction

endpackage

// File: rtl/stump_sequencer_if.sv
// Sequencer-side bus: run/memory handshake and flags in, decoder-facing state out.
interface stump_sequencer_if #(parameter int unsigned CNT_W = 16);
    import stump_sequencer_pkg::*;

    logic              run;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              cc_en;
    flags_t            flags_in;
    logic [1:0]        state;
    logic [DATA_W-1:0] ir;
    flags_t            cc;
    logic [CNT_W-1:0]  instr_count;
    logic              busy;

    modport master (
        input  run, mem_ready, mem_rdata, cc_en, flags_in,
        output state, ir, cc, instr_count, busy
    );

    modport slave (
        output run, mem_ready, mem_rdata, cc_en, flags_in,
        input  state, ir, cc, instr_count, busy
    );

endinterface

// File: rtl/stump_cc_reg.sv
// Condition-code register: loads the ALU flags when enabled, otherwise holds.
module stump_cc_reg
    import stump_sequencer_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  flags_t d,
    output flags_t q
);

    flags_t cc_q, cc_d;

    always_comb begin
        cc_d = cc_q;
        if (en) cc_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cc_q <= '0;
        else     cc_q <= cc_d;
    end

    assign q = cc_q;

endmodule

// File: rtl/stump_sequencer.sv
// Stump fetch/execute/memory sequencer: owns state, instruction register,
// condition codes and the retired-instruction counter.
module stump_sequencer
    import stump_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    stump_sequencer_if.master bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cc_en_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        count_d = count_q;
        cc_en_c = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.run && bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                // Flag writes are only honoured here, so cc_en elsewhere is don't-care.
                cc_en_c = bus.cc_en;
                if (is_ldst(ir_q)) begin
                    state_d = MEMORY;
                end else begin
                    state_d = FETCH;
                    count_d = count_q + CNT_W'(1);
                end
            end
            MEMORY: begin
                if (bus.mem_ready) begin
                    state_d = FETCH;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = FETCH;
        endcase
    end

    stump_cc_reg u_cc_reg (
        .clk (clk),
        .rst (rst),
        .en  (cc_en_c),
        .d   (bus.flags_in),
        .q   (bus.cc)
    );

    assign bus.state       = 2'(state_q);
    assign bus.ir          = ir_q;
    assign bus.instr_count = count_q;
    assign bus.busy        = (state_q != FETCH) || bus.run;

endmodule

// File: tb/tb_stump_sequencer.sv
// Directed bench for stump_sequencer: instruction-level model checked every cycle,
// plus hand-computed checkpoints; a 2-bit-counter twin exercises wrap-around.
module tb_stump_sequencer;

    logic clk;
    logic rst;

    stump_sequencer_if #(.CNT_W(16)) bus ();
    stump_sequencer_if #(.CNT_W(2))  sbus ();

    assign sbus.run       = bus.run;
    assign sbus.mem_ready = bus.mem_ready;
    assign sbus.mem_rdata = bus.mem_rdata;
    assign sbus.cc_en     = bus.cc_en;
    assign sbus.flags_in  = bus.flags_in;

    stump_sequencer #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
    stump_sequencer #(.CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(sbus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: which instruction is in flight and what it still owes.
    logic [15:0] m_ir;
    logic [3:0]  m_cc;
    int unsigned m_retired;
    bit          m_exec;
    bit          m_mem;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ir = 16'h0; m_cc = 4'h0; m_retired = 0; m_exec = 0; m_mem = 0;
        end else if (m_exec) begin
            if (bus.cc_en) m_cc = bus.flags_in;
            m_exec = 0;
            if (m_ir[15:13] == 3'b111) m_mem = 1;
            else m_retired++;
        end else if (m_mem) begin
            if (bus.mem_ready) begin
                m_mem = 0;
                m_retired++;
            end
        end else if (bus.run && bus.mem_ready) begin
            m_ir   = bus.mem_rdata;
            m_exec = 1;
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp_state;
        if (!rst) begin
            exp_state = m_exec ? 2'b01 : (m_mem ? 2'b10 : 2'b00);
            chk("state", 32'(bus.state), 32'(exp_state));
            chk("ir", 32'(bus.ir), 32'(m_ir));
            chk("cc", 32'(bus.cc), 32'(m_cc));
            chk("instr_count", 32'(bus.instr_count), m_retired % 65536);
            chk("instr_count_w2", 32'(sbus.instr_count), m_retired % 4);
            chk("busy", 32'(bus.busy), 32'(m_exec | m_mem | bus.run));
        end
    end

    // Drive one cycle's inputs, then sample just after the edge.
    task automatic cyc(input logic run, input logic rdy, input logic [15:0] rdata,
                       input logic ccen, input logic [3:0] flags);
        bus.run       = run;
        bus.mem_ready = rdy;
        bus.mem_rdata = rdata;
        bus.cc_en     = ccen;
        bus.flags_in  = flags;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0;
        bus.cc_en = 1'b0; bus.flags_in = 4'h0;
        @(posedge clk); #1;
        chk("rst_state", 32'(bus.state), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ir", 32'(bus.ir), 32'h0);
        chk("rst_count", 32'(bus.instr_count), 32'h0);

        // ALU instruction: FETCH -> EXECUTE -> FETCH, flags captured in EXECUTE
        cyc(1'b1, 1'b1, 16'h0A25, 1'b0, 4'h0);
        chk("alu_ir", 32'(bus.ir), 32'h0A25);
        chk("alu_exec", 32'(bus.state), 32'h1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 4'b1010);
        chk("alu_count", 32'(bus.instr_count), 32'h1);
        chk("alu_cc", 32'(bus.cc), 32'hA);
        chk("alu_fetch", 32'(bus.state), 32'h0);

        // Load with two wait cycles; cc_en outside EXECUTE must be ignored
        cyc(1'b1, 1'b1, 16'hE123, 1'b1, 4'b0101);
        chk("ld_cc_fetch", 32'(bus.cc), 32'hA);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
        chk("ld_mem", 32'(bus.state), 32'h2);
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 4'b0101);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 4'b0101);
        chk("ld_hold_count", 32'(bus.instr_count), 32'h1);
        cyc(1'b0, 1'b1, 16'h0, 1'b1, 4'b0101);
        chk("ld_count", 32'(bus.instr_count), 32'h2);
        chk("ld_cc_mem", 32'(bus.cc), 32'hA);
        chk("ld_ir", 32'(bus.ir), 32'hE123);

        // Halt: memory ready but run low, nothing is fetched
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 16'hFFFF, 1'b1, 4'b0101);
        chk("halt_state", 32'(bus.state), 32'h0);
        chk("halt_ir", 32'(bus.ir), 32'hE123);
        chk("halt_busy", 32'(bus.busy), 32'h0);

        // Single step: one run pulse retires exactly one instruction
        cyc(1'b1, 1'b1, 16'h1234, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'hFFFF, 1'b0, 4'h0);
        chk("step_ir", 32'(bus.ir), 32'h1234);
        chk("step_count", 32'(bus.instr_count), 32'h3);
        chk("step_state", 32'(bus.state), 32'h0);

        // Mixed back-to-back batch; the 2-bit twin wraps several times
        for (int i = 0; i < 20; i++) begin
            logic [15:0] w;
            bit          ld;
            ld = (i % 3) == 0;
            w  = ld ? (16'hE000 | 16'(i)) : (16'h0800 | 16'(i));
            cyc(1'b1, 1'b1, w, 1'b0, 4'h0);
            cyc(1'b1, 1'b0, 16'h0, 1'(i), 4'(i));
            if (ld) begin
                for (int k = 0; k < i % 4; k++) cyc(1'b1, 1'b0, 16'h0, 1'b1, 4'hF);
                cyc(1'b1, 1'b1, 16'hBEEF, 1'b1, 4'hF);
            end
        end
        bus.run = 1'b0;
        chk("batch_count", 32'(bus.instr_count), 32'd23);
        chk("batch_count_w2", 32'(sbus.instr_count), 32'd3);
        chk("batch_cc", 32'(bus.cc), 32'h3);

        // Reset asserted between edges while a load waits in MEMORY
        cyc(1'b1, 1'b1, 16'hE000, 1'b1, 4'hC);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 4'hC);
        chk("pre_rst_mem", 32'(bus.state), 32'h2);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.state), 32'h0);
        chk("async_rst_ir", 32'(bus.ir), 32'h0);
        chk("async_rst_cc", 32'(bus.cc), 32'h0);
        chk("async_rst_count", 32'(bus.instr_count), 32'h0);
        cyc(1'b0, 1'b1, 16'h0, 1'b0, 4'h0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 16'h0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 16'h0, 1'b0, 4'h0);
        chk("post_rst_state", 32'(bus.state), 32'h0);
        chk("post_rst_count", 32'(bus.instr_count), 32'h0);

        // One more ALU retire after reset
        cyc(1'b1, 1'b1, 16'h2001, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
        chk("final_count", 32'(bus.instr_count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
